// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
interface rr_grant_arbiter_if #(
  parameter int N = 5
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [2:0]     state;
  logic           timeout_pulse;

  modport master (
    output req,
    input  grant, grant_valid, grant_id, state, timeout_pulse
  );

  modport slave (
    input  req,
    output grant, grant_valid, grant_id, state, timeout_pulse
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a one-hot IDLE/BUSY/GAP FSM and a hold-time cap,
// so one requester cannot keep the shared resource indefinitely.
module rr_grant_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_grant_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    GAP  = 3'b100
  } state_e;

  state_e         state_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] ptr_q;
  logic [HW-1:0]  hold_q;
  logic           tout_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] ptr_d;

  // Scan from the far end of the rotated order so the closest match to ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
    win_oh[win_id] = win_found;
    ptr_d = (int'(win_id) == N - 1) ? '0 : win_id + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      tout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          tout_q <= 1'b0;
          if (win_found) begin
            state_q    <= BUSY;
            grant_q    <= win_oh;
            grant_id_q <= win_id;
            ptr_q      <= ptr_d;
            hold_q     <= HW'(1);
          end else begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
          end
        end
        BUSY: begin
          // A release on the cap edge counts as a normal release, hence req first.
          if (!bus.req[grant_id_q]) begin
            state_q    <= GAP;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
            tout_q     <= 1'b0;
          end else if (hold_q == HW'(MAX_HOLD)) begin
            state_q    <= GAP;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
            tout_q     <= 1'b1;
          end else begin
            hold_q     <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
          hold_q     <= '0;
          tout_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = |grant_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.state         = state_q;
  assign bus.timeout_pulse = tout_q;
endmodule
